// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int         DATA_W      = 8;
  localparam logic [7:0] DIVISOR_MIN = 8'd3;

  // Very small divisors cannot be timed by the bit counter; they are raised to the minimum.
  function automatic logic [7:0] clamp_divisor(input logic [7:0] div);
    return (div < DIVISOR_MIN) ? DIVISOR_MIN : div;
  endfunction

endpackage

// File: rtl/uart_baudtick.sv
// Bit-period timer: latches the clamped divisor on each transfer and pulses tick_o
// on the last cycle of every bit period while a frame is active.
module uart_baudtick
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       notreset_i,
  input  logic       load_i,
  input  logic       active_i,
  input  logic [7:0] divisor_i,
  output logic       tick_o
);

  logic [7:0] d_q, d_d;
  logic [7:0] cnt_q, cnt_d;

  assign tick_o = active_i & (cnt_q == 8'd0);

  always_comb begin
    d_d   = d_q;
    cnt_d = cnt_q;
    if (load_i) begin
      d_d   = clamp_divisor(divisor_i);
      cnt_d = d_d - 8'd1;
    end else if (tick_o) begin
      cnt_d = d_q - 8'd1;
    end else if (active_i) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!notreset_i) begin
      d_q   <= DIVISOR_MIN;
      cnt_q <= 8'd0;
    end else begin
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Byte-stream to asynchronous UART frame serialiser (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              notreset,
  input  logic [7:0]        divisor,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              txd,
  output logic              busy
);
  import uart_pkg::*;

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              txd_q, txd_d;
  logic              busy_q;
  logic              xfer, tick, active;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign ready  = notreset & enable & (state_q == IDLE);
  assign xfer   = valid & ready;
  assign active = (state_q != IDLE);
  assign txd    = txd_q;
  assign busy   = busy_q;

  uart_baudtick u_baudtick (
    .clk_i      (clk),
    .notreset_i (notreset),
    .load_i     (xfer),
    .active_i   (active),
    .divisor_i  (divisor),
    .tick_o     (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: if (xfer) begin
        state_d = START;
        shreg_d = data;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shreg_d = shreg_q >> 1;
        if (bit_q == LAST_BIT) state_d = AFTER_DATA;
        else                   bit_d   = bit_q + BIT_W'(1);
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (xfer) parity_d = ^data;
  end
`endif

  // Line level is registered, so txd trails the state by one cycle.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!notreset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame-level reference model plus literal frame checks.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       notreset;
  logic [7:0] divisor;
  logic       enable;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       txd;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(.DATA_W(8)) dut (
    .clk      (clk),
    .notreset (notreset),
    .divisor  (divisor),
    .enable   (enable),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .txd      (txd),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a frame is a list of line levels, one per clock, queued at acceptance.
  bit   line[$];
  int   rem = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   xfer_cyc = 0;
  int   m_d;
  bit   m_x;
  bit   bv;
  logic exp_txd, exp_busy, exp_ready;

  always @(posedge clk) begin
    cyc++;
    if (!notreset) begin
      rem = 0;
      line.delete();
      exp_txd  = 1'b1;
      exp_busy = 1'b0;
    end else begin
      m_x = valid && enable && (rem == 0);
      if (line.size() > 0) exp_txd = line.pop_front();
      else                 exp_txd = 1'b1;
      if (rem > 0) rem--;
      if (m_x) begin
        m_d = (divisor < 8'd3) ? 3 : int'(divisor);
        for (int s = 0; s < NB; s++) begin
          if (s == 0)                 bv = 1'b0;
          else if (s <= 8)            bv = data[s-1];
          else if (PAR_EN && s == 9)  bv = ^data;
          else                        bv = 1'b1;
          repeat (m_d) line.push_back(bv);
        end
        rem = NB * m_d;
        xfer_cnt++;
        xfer_cyc = cyc;
      end
      exp_busy = (rem > 0);
    end
    #1;
    exp_ready = notreset && enable && (rem == 0);
    chk("txd", txd, exp_txd);
    chk("busy", busy, exp_busy);
    chk("ready", ready, exp_ready);
  end

  task automatic send(input logic [7:0] b, input logic [7:0] div);
    int n0;
    int t;
    n0 = xfer_cnt;
    t  = 0;
    @(negedge clk);
    data    = b;
    divisor = div;
    valid   = 1'b1;
    while (xfer_cnt == n0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    valid = 1'b0;
    if (xfer_cnt == n0) chk_int("send_timeout", 0, 1);
  endtask

  // Sends one byte and checks each bit slot mid-period against a hand-written frame.
  task automatic lit_frame(input string tag, input logic [7:0] b, input logic [7:0] div,
                           input int dd, input logic [10:0] bits, input int zeros);
    int busy_n;
    int rdy_n;
    int zero_n;
    busy_n = 0;
    rdy_n  = 0;
    zero_n = 0;
    send(b, div);
    for (int c = 0; c < NB * dd + 4; c++) begin
      if (c > 0) @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (ready === 1'b1 && c < NB * dd) rdy_n++;
      if (txd === 1'b0) zero_n++;
      if (c >= 1 && ((c - 1) % dd) == dd / 2 && ((c - 1) / dd) < NB)
        chk({tag, "_bit"}, txd, bits[(c - 1) / dd]);
    end
    chk_int({tag, "_busy_cycles"}, busy_n, NB * dd);
    chk_int({tag, "_ready_during_frame"}, rdy_n, 0);
    chk_int({tag, "_low_cycles"}, zero_n, zeros);
  endtask

  initial begin
    int n0;
    int t;
    int k1;
    int k2;
    notreset = 1'b0;
    enable   = 1'b0;
    valid    = 1'b0;
    data     = 8'h00;
    divisor  = 8'd5;
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", ready, 1'b0);
    notreset = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    #1;
    chk("ready_follows_enable", ready, 1'b1);

`ifdef UART_TX_PARITY_EN
    lit_frame("basic_A5", 8'hA5, 8'd5, 5, 11'b10101001010, 30);
    lit_frame("parity_07", 8'h07, 8'd5, 5, 11'b11000001110, 30);
    lit_frame("clamp_FF", 8'hFF, 8'd2, 3, 11'b10111111110, 6);
`else
    lit_frame("basic_A5", 8'hA5, 8'd5, 5, 11'b01101001010, 25);
    lit_frame("clamp_FF", 8'hFF, 8'd2, 3, 11'b01111111110, 3);
`endif

    send(8'h3C, 8'd5);
    repeat (12) @(negedge clk);
    divisor = 8'd9;
`ifdef UART_TX_PARITY_EN
    lit_frame("latch_3C", 8'h3C, 8'd9, 9, 11'b10001111000, 54);
`else
    lit_frame("latch_3C", 8'h3C, 8'd9, 9, 11'b01001111000, 45);
`endif

    send(8'h5A, 8'd4);
    repeat (18) @(negedge clk);
    notreset = 1'b0;
    @(negedge clk);
    chk("midreset_txd", txd, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    notreset = 1'b1;
`ifdef UART_TX_PARITY_EN
    lit_frame("after_reset_81", 8'h81, 8'd4, 4, 11'b10100000010, 32);
`else
    lit_frame("after_reset_81", 8'h81, 8'd4, 4, 11'b01100000010, 28);
`endif

    enable  = 1'b0;
    valid   = 1'b1;
    data    = 8'h55;
    divisor = 8'd5;
    repeat (20) @(negedge clk);
    chk("gated_ready", ready, 1'b0);
    chk("gated_txd", txd, 1'b1);
    n0 = xfer_cnt;
    enable = 1'b1;
    t = 0;
    while (xfer_cnt == n0 && t < 100) begin @(negedge clk); t++; end
    k1 = xfer_cyc;
    data = 8'h33;
    t = 0;
    while (xfer_cnt < n0 + 2 && t < 300) begin @(negedge clk); t++; end
    k2 = xfer_cyc;
    valid = 1'b0;
    chk_int("b2b_count", xfer_cnt - n0, 2);
    chk_int("b2b_period", k2 - k1, NB * 5 + 1);
    chk("b2b_gap_high", txd, 1'b1);
    @(negedge clk);
    chk("b2b_second_start", txd, 1'b0);
    repeat (NB * 5 + 4) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid    = ($urandom_range(0, 3) != 0);
      data     = 8'($urandom);
      divisor  = 8'($urandom_range(0, 12));
      enable   = ($urandom_range(0, 7) != 0);
      notreset = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    valid    = 1'b0;
    enable   = 1'b1;
    notreset = 1'b1;
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

- Serialises one byte per handshake onto `txd` as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even-parity bit, one stop bit.
- Sits directly downstream of the baud rate divisor register and consumes its 8-bit output as the number of `clk` cycles per serial bit.
- Also consumes the UART enable and a byte-wide valid/ready stream from the data register.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; only 8 is supported.

Ports:
- `clk` input 1: single clock; all logic is sampled on its rising edge.
- `notreset` input 1: synchronous, active-low reset.
- `divisor` input 8: `clk` cycles per serial bit, taken from the baud rate divisor register.
- `enable` input 1: UART enable; new frames are accepted only while it is high.
- `data` input 8: byte to transmit.
- `valid` input 1: `data` is presented for transfer.
- `ready` output 1: block can accept a byte this cycle.
- `txd` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress.

## Operation
- States are IDLE, START, DATA, PARITY (only when the parity feature is compiled in) and STOP.
- **Accept**: a transfer occurs on a rising edge where `valid & ready`. `ready = enable & (state == IDLE)`, combinational from state and `enable`.
- **Latching on transfer**: `data` is loaded into a shift register. `divisor` is loaded into a latched D.
  - If `divisor < 3`, D = 3.
  - Later changes to `divisor` have no effect until the next transfer.
- **Bit timing**: each state holds for exactly D cycles, timed by a bit counter running from D-1 down to 0.
- **Transitions**:
  - IDLE -> START on transfer.
  - START -> DATA when the count expires.
  - DATA shifts right once per expiry. After bit 7 it goes to PARITY, or to STOP when parity is compiled out.
  - PARITY -> STOP when the count expires.
  - STOP -> IDLE when the count expires.
- **`txd` by state**: IDLE 1, START 0, DATA shift-register bit 0, PARITY XOR of the 8 latched bits (even parity), STOP 1. `txd` is registered.
- **Enable**: deasserting `enable` mid-frame does not abort the frame; it completes normally and no new byte is accepted.
- **`busy`**: registered; 1 in every state except IDLE.
- **Reset**: when `notreset` is low at a rising edge, the state becomes IDLE, `txd` 1 and `busy` 0 after that edge. This holds mid-frame; the partial frame is dropped. `ready` is 0 while `notreset` is low.

## Timing
- Reset values: `txd` 1, `busy` 0, `ready` follows `enable` once out of reset.
- **Latency**: transfer at edge k. `txd` goes low after edge k+1 and holds for D cycles.
  - Data bit i occupies cycles starting k+1+(1+i)·D.
  - Stop bit starts at k+1+9·D (k+1+10·D with parity).
- **Frame length**: 10·D cycles of line time (11·D with parity).
- **Back-to-back**: `ready` rises the cycle after STOP expires. With `valid` held high, the next start bit begins one cycle after the previous stop bit ends, giving a 10·D+1 cycle period.
- **Wrap-around**: none. The counter is 8-bit and D ≤ 255, so it never wraps.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined**: the PARITY state exists and an even-parity bit is inserted between bit 7 and the stop bit; frames are 11·D cycles.
- **Undefined**: there is no PARITY state and no parity logic; frames are 10·D cycles.

## Structure
- **Package `uart_pkg`**:
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `DATA_W = 8` and `DIVISOR_MIN = 3`.
- **Sub-module `uart_baudtick`**:
  - loads D on transfer and on each bit boundary;
  - counts down and pulses `tick` on the last cycle of each bit period;
  - the top-level FSM advances only on `tick`.

## Test plan
- **Basic frame**: reset, `divisor`=5, `enable`=1, send 0xA5 -> `txd` = 0,1,0,1,0,0,1,0,1,1, each bit held 5 cycles; `busy` high for 50 cycles; `ready` low throughout the frame.
- **Parity**: with `UART_TX_PARITY_EN`, send 0xA5 -> parity bit 0 (four ones). Send 0x07 -> parity bit 1. Frame is 55 cycles at D=5.
- **Divisor latch**: start a frame at `divisor`=5 and change it to 9 mid-frame -> remaining bits stay 5 cycles each; the next frame uses 9.
- **Clamp**: `divisor`=2, send 0xFF -> each bit lasts 3 cycles.
- **Reset mid-frame**: assert `notreset` low during data bit 3 -> after the next edge `txd`=1, `busy`=0, state IDLE. After release, a new byte transmits cleanly.
- **Enable gating and back-to-back**:
  - `enable`=0 with `valid`=1 -> `ready`=0 and `txd` stays 1.
  - With `enable`=1 and `valid` held, two bytes are sent with the second start bit beginning exactly one cycle after the first stop bit ends.
